// File: rtl/reaction_timer_ms.sv
// Reaction timer: random pre-light delay from an LFSR, then a BCD millisecond count
// until stop, with early-press and saturation flags held for the display mux.
module reaction_timer_ms #(
   parameter int CLK_HZ      = 50_000_000,
   parameter int TICK_HZ     = 1000,
   parameter int DIGITS      = 4,
   parameter int MIN_WAIT_MS = 2000,
   parameter int RAND_BITS   = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  start,
   input  logic                  stop,
   output logic                  led,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  done_tick,
   output logic                  early,
   output logic                  timeout,
   output logic [2:0]            state_dbg
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int WW  = $clog2(MIN_WAIT_MS + 2**RAND_BITS);
   localparam int BW  = 4 * DIGITS;
   localparam logic [BW-1:0] ALL9 = {DIGITS{4'h9}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT    = 3'd1,
      S_MEASURE = 3'd2,
      S_DONE    = 3'd3,
      S_EARLY   = 3'd4
   } state_t;

   state_t          state, state_n;
   logic            start_q, stop_q, primed;
   logic            start_e, stop_e;
   logic [15:0]     lfsr;
   logic [PW-1:0]   presc;
   logic            ms_tick;
   logic            presc_clr;
   logic [WW-1:0]   wait_cnt, wait_n, wait_load;
   logic [BW-1:0]   bcd_r, bcd_n;
   logic            done_r, done_n;
   logic            early_r, early_n;
   logic            timeout_r, timeout_n;

   function automatic logic [BW-1:0] bcd_incr(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (r[4*i +: 4] >= 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // primed masks the first cycle after reset so a level held across reset is not an edge
   assign start_e   = start & ~start_q & primed;
   assign stop_e    = stop & ~stop_q & primed;
   assign ms_tick   = (presc == PW'(DIV - 1));
   assign wait_load = WW'(MIN_WAIT_MS) + WW'(lfsr[RAND_BITS-1:0]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         primed  <= 1'b0;
         lfsr    <= 16'hACE1;
      end else begin
         start_q <= start;
         stop_q  <= stop;
         primed  <= 1'b1;
         lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
      end else if (clear || presc_clr || ms_tick) begin
         presc <= '0;
      end else if (state == S_WAIT || state == S_MEASURE) begin
         presc <= presc + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         bcd_r     <= '0;
         done_r    <= 1'b0;
         early_r   <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         state     <= state_n;
         wait_cnt  <= wait_n;
         bcd_r     <= bcd_n;
         done_r    <= done_n;
         early_r   <= early_n;
         timeout_r <= timeout_n;
      end
   end

   always_comb begin
      state_n   = state;
      wait_n    = wait_cnt;
      bcd_n     = bcd_r;
      done_n    = 1'b0;
      early_n   = early_r;
      timeout_n = timeout_r;
      presc_clr = 1'b0;
      if (clear) begin
         state_n   = S_IDLE;
         bcd_n     = '0;
         early_n   = 1'b0;
         timeout_n = 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_EARLY: begin
               if (start_e) begin
                  state_n   = S_WAIT;
                  wait_n    = wait_load;
                  bcd_n     = '0;
                  early_n   = 1'b0;
                  timeout_n = 1'b0;
                  presc_clr = 1'b1;
               end
            end
            S_WAIT: begin
               if (stop_e) begin
                  state_n = S_EARLY;
                  early_n = 1'b1;
                  bcd_n   = '0;
               end else if (wait_cnt == '0) begin
                  state_n   = S_MEASURE;
                  presc_clr = 1'b1;
               end else if (ms_tick) begin
                  wait_n = wait_cnt - 1'b1;
                  if (wait_cnt == WW'(1)) begin
                     state_n   = S_MEASURE;
                     presc_clr = 1'b1;
                  end
               end
            end
            S_MEASURE: begin
               // a stop edge wins over a tick landing in the same cycle
               if (stop_e) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end else if (ms_tick) begin
                  if (bcd_r == ALL9) begin
                     state_n   = S_DONE;
                     done_n    = 1'b1;
                     timeout_n = 1'b1;
                  end else begin
                     bcd_n = bcd_incr(bcd_r);
                  end
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   assign led       = (state == S_MEASURE);
   assign busy      = (state == S_WAIT) || (state == S_MEASURE);
   assign bcd       = bcd_r;
   assign done_tick = done_r;
   assign early     = early_r;
   assign timeout   = timeout_r;
   assign state_dbg = state;

endmodule

// File: tb/tb_reaction_timer_ms.sv
// Directed bench for reaction_timer_ms at DIV=10, MIN_WAIT=4, RAND_BITS=2, DIGITS=2.
module tb_reaction_timer_ms;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        led, busy, done_tick, early, timeout;
   logic [7:0]  bcd;
   logic [2:0]  state_dbg;
   logic [12:0] outs;

   int n_assert = 0;
   int n_fail   = 0;
   logic [8:0]  exp_q[$];
   logic [15:0] m_lfsr;

   reaction_timer_ms #(
      .CLK_HZ(1000), .TICK_HZ(100), .DIGITS(2), .MIN_WAIT_MS(4), .RAND_BITS(2)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear), .start(start), .stop(stop),
      .led(led), .bcd(bcd), .busy(busy), .done_tick(done_tick),
      .early(early), .timeout(timeout), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   assign outs = {led, busy, done_tick, early, timeout, bcd};

   always @(posedge clk or posedge reset) begin
      if (reset) m_lfsr <= 16'hACE1;
      else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // m_lfsr here already holds the value the DUT samples at the coming edge
   task automatic do_start(output int n);
      n = 4 + int'(m_lfsr[1:0]);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_led(input string tag, input int n);
      int cnt;
      cnt = 0;
      while (!led && cnt < 10*n + 40) begin
         cyc(1);
         cnt++;
      end
      check(tag, cnt, 10*n);
   endtask

   task automatic wait_done(input string tag);
      int cnt;
      logic [8:0] e;
      cnt = 0;
      while (!done_tick && cnt < 1200) begin
         cyc(1);
         cnt++;
      end
      check({tag, "_pulse"}, done_tick, 1'b1);
      check({tag, "_have_exp"}, exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_result"}, {timeout, bcd}, e);
      end
      check({tag, "_led_off"}, {led, busy, early}, 3'b000);
      cyc(1);
      check({tag, "_pulse_end"}, done_tick, 1'b0);
   endtask

   initial begin
      int n;
      int seen;
      #500000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;
      // start held high through reset must not launch a trial
      start = 1'b1;
      #23 reset = 1'b0;
      cyc(1);
      check("reset_outs", outs, 13'd0);
      cyc(3);
      check("no_edge_through_reset", busy, 1'b0);
      start = 1'b0;
      cyc(1);

      // trial 1: delay from LFSR model, stop 73 clocks after light
      do_start(n);
      check("busy_after_start", {busy, led}, 2'b10);
      wait_led("delay1", n);
      check("measure_bcd0", bcd, 8'h00);
      cyc(72);
      stop = 1'b1;
      exp_q.push_back({1'b0, 8'h07});
      cyc(1);
      stop = 1'b0;
      wait_done("trial1");

      // early press during WAIT
      do_start(n);
      cyc(5);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      check("early_outs", outs, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
      seen = 0;
      repeat (60) begin
         cyc(1);
         if (led || done_tick) seen++;
      end
      check("early_quiet", seen, 0);
      check("early_held", early, 1'b1);

      // restart clears early; no stop -> saturate at 99
      do_start(n);
      check("early_cleared", {early, busy}, 2'b01);
      wait_led("delay3", n);
      exp_q.push_back({1'b1, 8'h99});
      cyc(990);
      check("count_99", {timeout, led, bcd}, {1'b0, 1'b1, 8'h99});
      wait_done("timeout");
      seen = 0;
      repeat (20) begin
         cyc(1);
         if (done_tick) seen++;
      end
      check("timeout_single_pulse", seen, 0);
      check("timeout_held", {timeout, bcd}, {1'b1, 8'h99});

      // start ignored in MEASURE; stop coinciding with the 4th tick
      do_start(n);
      check("timeout_cleared", {timeout, bcd}, 9'd0);
      wait_led("delay5", n);
      cyc(14);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      check("start_ignored", {led, busy}, 2'b11);
      cyc(24);
      check("count_3", bcd, 8'h03);
      stop = 1'b1;
      exp_q.push_back({1'b0, 8'h03});
      cyc(1);
      stop = 1'b0;
      wait_done("stop_on_tick");

      // clear mid-WAIT, clear beating start, clear mid-MEASURE
      do_start(n);
      cyc(10);
      check("wait_busy", {busy, led}, 2'b10);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      check("clear_wait", outs, 13'd0);
      clear = 1'b1;
      start = 1'b1;
      cyc(1);
      clear = 1'b0;
      start = 1'b0;
      check("clear_beats_start", busy, 1'b0);
      cyc(1);
      do_start(n);
      wait_led("delay6", n);
      cyc(25);
      check("count_2", bcd, 8'h02);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      check("clear_measure", outs, 13'd0);

      // async reset mid-MEASURE, then a trial from the reseeded LFSR
      do_start(n);
      wait_led("delay7", n);
      cyc(15);
      #2 reset = 1'b1;
      #1 check("async_reset", outs, 13'd0);
      #10 reset = 1'b0;
      cyc(2);
      do_start(n);
      wait_led("delay_reseed", n);
      cyc(20);
      stop = 1'b1;
      exp_q.push_back({1'b0, 8'h02});
      cyc(1);
      stop = 1'b0;
      wait_done("after_reset");

      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
